// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants and fetch FSM state encoding.
// Imported by the fetch stage and its next-PC helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_READY,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Priority: jump, then taken branch, then sequential; wrap is silent.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] index,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic [31:0] imm_sext;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign imm_sext      = {{16{index[15]}}, index[15:0]};
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], index, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IR and the req/ack fetch FSM.
// Optional PC bounds checking is enabled by defining PC_BOUNDS_CHECK_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pcupdate,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted,
    output logic        seq_err,
    output logic        fault
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    fetch_state_t state, state_next;

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] next_pc;
    logic        seq_err_q;
    logic        fault_q;
    logic        load_pc;
    logic        load_ir;
    logic        set_seq_err;
    logic        set_fault;
    logic        oob;
    logic        fault_hit;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .index    (ir_q[25:0]),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    assign oob = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= PC_LIMIT);

`ifdef PC_BOUNDS_CHECK_EN
    assign fault_hit = oob;
`else
    logic unused_oob;
    assign fault_hit  = 1'b0;
    assign unused_oob = oob;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_pc     = 1'b0;
        load_ir     = 1'b0;
        set_seq_err = 1'b0;
        set_fault   = 1'b0;
        case (state)
            ST_FETCH, ST_WAIT: begin
                set_seq_err = pcupdate;
                if (imem_ack) begin
                    load_ir    = 1'b1;
                    state_next = (imem_rdata[31:26] == OP_HALT) ? ST_HALT : ST_READY;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_READY: begin
                if (pcupdate) begin
                    load_pc    = 1'b1;
                    state_next = ST_FETCH;
                    // A bad target halts before any request leaves the stage
                    if (fault_hit) begin
                        set_fault  = 1'b1;
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            seq_err_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (load_pc) begin
                pc_q <= next_pc;
            end
            if (load_ir) begin
                ir_q <= imem_rdata;
            end
            if (set_seq_err) begin
                seq_err_q <= 1'b1;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Request is masked during reset so an in-flight fetch drops at once
    assign imem_req    = !reset && ((state == ST_FETCH) || (state == ST_WAIT));
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[5:0];
    assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign instr_valid = (state == ST_READY) || (state == ST_HALT);
    assign halted      = (state == ST_HALT);
    assign seq_err     = seq_err_q;
    assign fault       = fault_q;

endmodule
